// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-master SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef logic mst_t;

    localparam mst_t MST_CPU = 1'b0;
    localparam mst_t MST_LD  = 1'b1;

    localparam int unsigned ADDR_W_DEF = 20;
    localparam int unsigned DATA_W_DEF = 16;

    // SRAM strobes are active low; this is their idle level
    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Request/response channels of the two SRAM masters (CPU and loader).
interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_be;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              ld_req;
    logic              ld_we;
    logic [1:0]        ld_be;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_ack;

    modport master (
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output ld_req, ld_we, ld_be, ld_addr, ld_wdata,
        input  ld_rdata, ld_ack
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  ld_req, ld_we, ld_be, ld_addr, ld_wdata,
        output ld_rdata, ld_ack
    );

endinterface

// File: rtl/sram_arbiter_pick.sv
// Two-way round-robin picker; only built when SRAM_ARBITER_RR_EN is defined.
`ifdef SRAM_ARBITER_RR_EN
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic ld_req,
    input  logic advance,
    output mst_t win
);
    mst_t last;

    // On a tie the master not served last wins; a lone request always wins
    always_comb begin
        win = MST_CPU;
        if (cpu_req && ld_req) begin
            win = mst_t'(~last);
        end else if (ld_req) begin
            win = MST_LD;
        end
    end

    // Pointer moves only when a transaction is launched; reset favours the CPU
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= MST_LD;
        end else if (advance) begin
            last <= win;
        end
    end

endmodule
`endif

// File: rtl/sram_arbiter.sv
// Two-master arbiter and fixed-length cycle sequencer for the async SRAM.
// Define SRAM_ARBITER_RR_EN for round-robin ties; otherwise the CPU always wins.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF
)(
    input  logic              Clk,
    input  logic              Reset,
    sram_arbiter_if.slave     host,
    output logic [ADDR_W-1:0] A,
    inout  wire  [DATA_W-1:0] Mem_bus,
    output logic              CE,
    output logic              OE,
    output logic              WE,
    output logic              UB,
    output logic              LB,
    output logic              busy,
    output logic              grant
);
    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic              start;
    logic              capture;
    mst_t              win;
    mst_t              grant_n;

    logic              txn_we, txn_we_n;
    logic [1:0]        txn_be, txn_be_n;
    logic [DATA_W-1:0] txn_wdata;
    logic              bus_en;

    logic              sel_we;
    logic [1:0]        sel_be;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef SRAM_ARBITER_RR_EN
    sram_arb_pick u_pick (
        .clk     (Clk),
        .rst     (Reset),
        .cpu_req (host.cpu_req),
        .ld_req  (host.ld_req),
        .advance (start),
        .win     (win)
    );
`else
    // Fixed priority: CPU wins whenever it requests
    always_comb win = host.cpu_req ? MST_CPU : MST_LD;
`endif

    // Mux the winning master's request fields for latching
    always_comb begin
        sel_we    = host.cpu_we;
        sel_be    = host.cpu_be;
        sel_addr  = host.cpu_addr;
        sel_wdata = host.cpu_wdata;
        if (win == MST_LD) begin
            sel_we    = host.ld_we;
            sel_be    = host.ld_be;
            sel_addr  = host.ld_addr;
            sel_wdata = host.ld_wdata;
        end
    end

    // Next-state, wait counter and next transaction attributes
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        start   = 1'b0;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (host.cpu_req || host.ld_req) begin
                    start   = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                state_n = ACCESS;
                cnt_n   = 4'(WAIT_CYCLES - 1);
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_n = DONE;
                    capture = ~txn_we;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        txn_we_n = start ? sel_we : txn_we;
        txn_be_n = start ? sel_be : txn_be;
        grant_n  = start ? win    : grant;
    end

    // Registered state, latched request and every output, decoded from next state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            cnt            <= '0;
            txn_we         <= 1'b0;
            txn_be         <= '0;
            txn_wdata      <= '0;
            A              <= '0;
            grant          <= MST_CPU;
            busy           <= 1'b0;
            CE             <= STROBE_OFF;
            OE             <= STROBE_OFF;
            WE             <= STROBE_OFF;
            UB             <= STROBE_OFF;
            LB             <= STROBE_OFF;
            bus_en         <= 1'b0;
            host.cpu_ack   <= 1'b0;
            host.ld_ack    <= 1'b0;
            host.cpu_rdata <= '0;
            host.ld_rdata  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            txn_we <= txn_we_n;
            txn_be <= txn_be_n;
            grant  <= grant_n;
            if (start) begin
                txn_wdata <= sel_wdata;
                A         <= sel_addr;
            end
            busy   <= (state_n != IDLE);
            CE     <= (state_n == IDLE) ? STROBE_OFF : ~STROBE_OFF;
            OE     <= (state_n == ACCESS && !txn_we_n) ? ~STROBE_OFF : STROBE_OFF;
            WE     <= (state_n == ACCESS &&  txn_we_n) ? ~STROBE_OFF : STROBE_OFF;
            UB     <= (state_n == IDLE) ? STROBE_OFF : ~txn_be_n[1];
            LB     <= (state_n == IDLE) ? STROBE_OFF : ~txn_be_n[0];
            // write data stays on the bus through DONE for hold time
            bus_en <= txn_we_n && (state_n == ACCESS || state_n == DONE);
            host.cpu_ack <= (state_n == DONE) && (grant_n == MST_CPU);
            host.ld_ack  <= (state_n == DONE) && (grant_n == MST_LD);
            if (capture) begin
                if (grant == MST_LD) begin
                    host.ld_rdata <= Mem_bus;
                end else begin
                    host.cpu_rdata <= Mem_bus;
                end
            end
        end
    end

    assign Mem_bus = bus_en ? txn_wdata : 'z;

endmodule
